// File: rtl/input_debouncer_pkg.sv
// Shared defaults and sizing helper for the ui_in debouncer.
package input_debounce_pkg;

   localparam int DEB_WIDTH_DEF    = 8;
   localparam int DEB_CYCLES_DEF   = 4;
   localparam int DEB_PRESCALE_DEF = 1;

   // Bits needed to hold 0..max_val, never less than one.
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/input_debouncer_if.sv
// Raw-in / clean-out bundle between the ui_in pins and the debouncer.
interface input_debouncer_if
   import input_debounce_pkg::*;
#(
   parameter int WIDTH = DEB_WIDTH_DEF
) ();

   logic             ena;
   logic [WIDTH-1:0] sw_raw;
   logic [WIDTH-1:0] sw_stable;
   logic [WIDTH-1:0] sw_rise;
   logic [WIDTH-1:0] sw_fall;
   logic             any_change;

   modport master (
      output ena, sw_raw,
      input  sw_stable, sw_rise, sw_fall, any_change
   );

   modport slave (
      input  ena, sw_raw,
      output sw_stable, sw_rise, sw_fall, any_change
   );

endinterface

// File: rtl/input_debouncer_bit.sv
// One debounced input: 2-flop synchronizer, stability counter, stable level
// and edge pulses. Edge registers exist only with INPUT_DEBOUNCE_EDGE_EN defined.
module debounce_bit
   import input_debounce_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEB_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic ena,
   input  logic tick,
   input  logic raw,
   output logic stable,
   output logic rise,
   output logic fall
);

   localparam int               CNT_W = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1;
   logic             sync2;
   logic [CNT_W-1:0] cnt;
   logic             mismatch;
   logic             flip;

   assign mismatch = sync2 ^ stable;
   assign flip     = mismatch & tick & (cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1  <= 1'b0;
         sync2  <= 1'b0;
         cnt    <= '0;
         stable <= 1'b0;
      end else if (ena) begin
         sync1 <= raw;
         sync2 <= sync1;
         if (flip) begin
            stable <= sync2;
            cnt    <= '0;
         end else if (!mismatch) begin
            cnt <= '0;
         end else if (tick) begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

`ifdef INPUT_DEBOUNCE_EDGE_EN
   logic rise_q;
   logic fall_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         rise_q <= ena & flip & sync2;
         fall_q <= ena & flip & ~sync2;
      end
   end

   // Gate with ena so a pulse never shows while the block is paused.
   assign rise = rise_q & ena;
   assign fall = fall_q & ena;
`else
   assign rise = 1'b0;
   assign fall = 1'b0;
`endif

endmodule

// File: rtl/input_debouncer.sv
// Per-bit synchronizer/debouncer for ui_in with a shared sample prescaler.
// Edge pulses are built only when INPUT_DEBOUNCE_EDGE_EN is defined.
module input_debouncer
   import input_debounce_pkg::*;
#(
   parameter int WIDTH           = DEB_WIDTH_DEF,
   parameter int DEBOUNCE_CYCLES = DEB_CYCLES_DEF,
   parameter int PRESCALE        = DEB_PRESCALE_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input_debouncer_if.slave   bus
);

   logic             tick;
   logic [WIDTH-1:0] stable_w;
   logic [WIDTH-1:0] rise_w;
   logic [WIDTH-1:0] fall_w;

   generate
      if (PRESCALE <= 1) begin : g_no_prescale
         assign tick = 1'b1;
      end else begin : g_prescale
         localparam int            PS_W = cnt_width(PRESCALE - 1);
         localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

         logic [PS_W-1:0] pre_cnt;

         assign tick = (pre_cnt == PS_LAST);

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               pre_cnt <= '0;
            end else if (bus.ena) begin
               pre_cnt <= tick ? '0 : pre_cnt + PS_W'(1);
            end
         end
      end
   endgenerate

   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
         debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
         ) u_bit (
            .clk    (clk),
            .rst_n  (rst_n),
            .ena    (bus.ena),
            .tick   (tick),
            .raw    (bus.sw_raw[i]),
            .stable (stable_w[i]),
            .rise   (rise_w[i]),
            .fall   (fall_w[i])
         );
      end
   endgenerate

   assign bus.sw_stable  = stable_w;
   assign bus.sw_rise    = rise_w;
   assign bus.sw_fall    = fall_w;
   assign bus.any_change = |(rise_w | fall_w);

endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer: one instance at PRESCALE=1, one at PRESCALE=4.
module tb_input_debouncer;

`ifdef INPUT_DEBOUNCE_EDGE_EN
   localparam bit EDGE_EN = 1'b1;
`else
   localparam bit EDGE_EN = 1'b0;
`endif

   typedef struct {
      int         sel;
      int         when;
      logic [7:0] st;
   } sb_item_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   rel_cyc;
   int   errors;
   int   checks;

   sb_item_t   sb[$];
   logic [7:0] exp_st [2];
   logic [7:0] nst, e_ri, e_fa;
   logic [7:0] o_st, o_ri, o_fa;
   logic       o_any;

   input_debouncer_if #(.WIDTH(8)) bus1 ();
   input_debouncer_if #(.WIDTH(8)) bus4 ();

   input_debouncer #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .PRESCALE(1)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   input_debouncer #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .PRESCALE(4)) dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s @cyc %0d: got %0h, want %0h", tag, cyc, obs, exp);
      end
   endtask

   // Expected stable value for instance sel, visible after the edge numbered when.
   task automatic push(input int sel, input int when, input logic [7:0] st);
      sb_item_t it;
      int       pos;
      it.sel  = sel;
      it.when = when;
      it.st   = st;
      pos = sb.size();
      for (int i = 0; i < sb.size(); i++) begin
         if (sb[i].when > when) begin
            pos = i;
            break;
         end
      end
      sb.insert(pos, it);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Every falling edge: stable must hold its last expected value unless the
   // scoreboard says it flips now; pulses follow from the flip alone.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_st[0] = 8'h00;
         exp_st[1] = 8'h00;
      end else begin
         for (int s = 0; s < 2; s++) begin
            nst = exp_st[s];
            for (int i = sb.size() - 1; i >= 0; i--) begin
               if (sb[i].sel == s && sb[i].when == cyc) begin
                  nst = sb[i].st;
                  sb.delete(i);
               end
            end
            e_ri  = EDGE_EN ? (nst & ~exp_st[s]) : 8'h00;
            e_fa  = EDGE_EN ? (~nst & exp_st[s]) : 8'h00;
            o_st  = (s == 0) ? bus1.sw_stable  : bus4.sw_stable;
            o_ri  = (s == 0) ? bus1.sw_rise    : bus4.sw_rise;
            o_fa  = (s == 0) ? bus1.sw_fall    : bus4.sw_fall;
            o_any = (s == 0) ? bus1.any_change : bus4.any_change;
            check_val((s == 0) ? "p1_stable" : "p4_stable", {24'h0, o_st}, {24'h0, nst});
            check_val((s == 0) ? "p1_rise"   : "p4_rise",   {24'h0, o_ri}, {24'h0, e_ri});
            check_val((s == 0) ? "p1_fall"   : "p4_fall",   {24'h0, o_fa}, {24'h0, e_fa});
            check_val((s == 0) ? "p1_any"    : "p4_any",    {31'h0, o_any}, {31'h0, |(e_ri | e_fa)});
            exp_st[s] = nst;
         end
      end
   end

   initial begin
      int         p;
      int         j;
      int         n;
      logic [7:0] v;

      errors       = 0;
      checks       = 0;
      rel_cyc      = 0;
      rst_n        = 1'b0;
      bus1.ena     = 1'b1;
      bus1.sw_raw  = 8'h00;
      bus4.ena     = 1'b1;
      bus4.sw_raw  = 8'h00;

      // Reset and idle
      step(3);
      check_val("rst_stable", {24'h0, bus1.sw_stable}, 32'h0);
      check_val("rst_rise",   {24'h0, bus1.sw_rise},   32'h0);
      check_val("rst_fall",   {24'h0, bus1.sw_fall},   32'h0);
      check_val("rst_any",    {31'h0, bus1.any_change}, 32'h0);
      rst_n   = 1'b1;
      rel_cyc = cyc;
      step(100);

      // Clean rise on bit 0
      bus1.sw_raw = 8'h01;
      push(0, cyc + 6, 8'h01);
      step(12);

      // Bounce on bit 3: high 3 / low 1, then hold high
      for (int r = 0; r < 20; r++) begin
         bus1.sw_raw = 8'h09;
         step(3);
         bus1.sw_raw = 8'h01;
         step(1);
      end
      bus1.sw_raw = 8'h09;
      push(0, cyc + 6, 8'h09);
      step(12);

      // Reach 0x04, then swap to 0x02 in one cycle
      bus1.sw_raw = 8'h04;
      push(0, cyc + 6, 8'h04);
      step(12);
      bus1.sw_raw = 8'h02;
      push(0, cyc + 6, 8'h02);
      step(12);

      // Reset mid-count on bit 1
      bus1.sw_raw = 8'h00;
      push(0, cyc + 6, 8'h00);
      step(12);
      bus1.sw_raw = 8'h02;
      step(4);
      rst_n = 1'b0;
      #1;
      check_val("async_stable", {24'h0, bus1.sw_stable}, 32'h0);
      check_val("async_rise",   {24'h0, bus1.sw_rise},   32'h0);
      check_val("async_fall",   {24'h0, bus1.sw_fall},   32'h0);
      check_val("async_any",    {31'h0, bus1.any_change}, 32'h0);
      step(2);
      rst_n   = 1'b1;
      rel_cyc = cyc;
      push(0, cyc + 6, 8'h02);
      step(12);

      // ena low for 5 cycles in the middle of a fall
      bus1.sw_raw = 8'h00;
      push(0, cyc + 11, 8'h00);
      step(3);
      bus1.ena = 1'b0;
      step(5);
      bus1.ena = 1'b1;
      step(15);

      // Prescaled steps on bit 7 at shifting tick phases
      for (int ph = 0; ph < 4; ph++) begin
         v = (ph % 2 == 0) ? 8'h80 : 8'h00;
         bus4.sw_raw = v;
         p = (cyc - rel_cyc) % 4;
         j = 3;
         while ((p + j - 1) % 4 != 3) j++;
         n = j + 12;
         check_val("p4_latency_window", {31'h0, (n >= 15 && n <= 18)}, 32'h1);
         push(1, cyc + n, v);
         step(25 + ph);
      end

      // 10-cycle pulse must be rejected
      bus4.sw_raw = 8'h80;
      step(10);
      bus4.sw_raw = 8'h00;
      step(30);

      check_val("sb_drain", sb.size(), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
